// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the regression datapath: Q16.16 word format,
// accumulator width, state encoding and saturating narrowing/addition helpers.
package fpga_cfg_pkg;

  localparam int FP_WIDTH     = 32;
  localparam int FP_QINT      = 16;
  localparam int FP_QFRAC     = 16;
  localparam int FP_ONE       = 1 << FP_QFRAC;
  localparam int FP_ACC_WIDTH = 48;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EMIT  = 2'd2
  } acc_state_t;

  typedef struct packed {
    logic                ovf;
    logic [FP_WIDTH-1:0] val;
  } fx_sat_t;

  typedef struct packed {
    logic                    ovf;
    logic [FP_ACC_WIDTH-1:0] val;
  } acc_sum_t;

  // Narrow a signed double-width value to one word, clamping on overflow.
  function automatic fx_sat_t fx_sat(input logic [2*FP_WIDTH-1:0] v);
    fx_sat_t r;
    r.ovf = (v[2*FP_WIDTH-1:FP_WIDTH-1] != {(FP_WIDTH+1){v[2*FP_WIDTH-1]}});
    if (r.ovf) r.val = v[2*FP_WIDTH-1] ? {1'b1, {(FP_WIDTH-1){1'b0}}}
                                       : {1'b0, {(FP_WIDTH-1){1'b1}}};
    else       r.val = v[FP_WIDTH-1:0];
    return r;
  endfunction

  function automatic acc_sum_t acc_add(input logic [FP_ACC_WIDTH-1:0] a,
                                       input logic [FP_ACC_WIDTH-1:0] b);
    acc_sum_t              r;
    logic [FP_ACC_WIDTH:0] s;
    s = {a[FP_ACC_WIDTH-1], a} + {b[FP_ACC_WIDTH-1], b};
    r.ovf = (s[FP_ACC_WIDTH] != s[FP_ACC_WIDTH-1]);
    if (r.ovf) r.val = s[FP_ACC_WIDTH] ? {1'b1, {(FP_ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(FP_ACC_WIDTH-1){1'b1}}};
    else       r.val = s[FP_ACC_WIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/regression_basis_pipe.sv
// Three-stage basis expansion: (x, y) -> x, x^2, x^3, x^4, y, xy, x^2*y in Q16.16,
// with a sticky per-sample saturation bit travelling alongside the data.
module regression_basis_pipe
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int QFRAC = FP_QFRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_x2,
  output logic [WIDTH-1:0] out_x3,
  output logic [WIDTH-1:0] out_x4,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_xy,
  output logic [WIDTH-1:0] out_x2y,
  output logic             out_sat
);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } s1_t;

  typedef struct packed {
    logic             v;
    logic             sat;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] xy;
  } s2_t;

  typedef struct packed {
    logic             v;
    logic             sat;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] x3;
    logic [WIDTH-1:0] x4;
    logic [WIDTH-1:0] xy;
    logic [WIDTH-1:0] x2y;
  } s3_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;

  logic signed [2*WIDTH-1:0] p_xx, p_xy, p_x3, p_x4, p_x2y;
  fx_sat_t r_xx, r_xy, r_x3, r_x4, r_x2y;

  // Full-width signed products, arithmetic shift floors toward -inf.
  always_comb begin
    p_xx  = $signed(s1_q.x)  * $signed(s1_q.x);
    p_xy  = $signed(s1_q.x)  * $signed(s1_q.y);
    p_x3  = $signed(s2_q.x2) * $signed(s2_q.x);
    p_x4  = $signed(s2_q.x2) * $signed(s2_q.x2);
    p_x2y = $signed(s2_q.x2) * $signed(s2_q.y);
    r_xx  = fx_sat(p_xx  >>> QFRAC);
    r_xy  = fx_sat(p_xy  >>> QFRAC);
    r_x3  = fx_sat(p_x3  >>> QFRAC);
    r_x4  = fx_sat(p_x4  >>> QFRAC);
    r_x2y = fx_sat(p_x2y >>> QFRAC);
  end

  always_comb begin
    s1_d.v = in_valid;
    s1_d.x = x;
    s1_d.y = y;

    s2_d.v   = s1_q.v;
    s2_d.x   = s1_q.x;
    s2_d.y   = s1_q.y;
    s2_d.x2  = r_xx.val;
    s2_d.xy  = r_xy.val;
    s2_d.sat = r_xx.ovf | r_xy.ovf;

    s3_d.v   = s2_q.v;
    s3_d.x   = s2_q.x;
    s3_d.y   = s2_q.y;
    s3_d.x2  = s2_q.x2;
    s3_d.xy  = s2_q.xy;
    s3_d.x3  = r_x3.val;
    s3_d.x4  = r_x4.val;
    s3_d.x2y = r_x2y.val;
    s3_d.sat = s2_q.sat | r_x3.ovf | r_x4.ovf | r_x2y.ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign out_valid = s3_q.v;
  assign out_x     = s3_q.x;
  assign out_x2    = s3_q.x2;
  assign out_x3    = s3_q.x3;
  assign out_x4    = s3_q.x4;
  assign out_y     = s3_q.y;
  assign out_xy    = s3_q.xy;
  assign out_x2y   = s3_q.x2y;
  assign out_sat   = s3_q.sat;

endmodule

// File: rtl/regression_accumulator_3x3.sv
// Accumulates the normal equations A = sum(phi*phi'), B = sum(phi*y) for phi = [1, x, x^2].
// Element i of A_flat / B_flat occupies bits [i*WIDTH +: WIDTH] (element 0 at the LSBs).
module regression_accumulator_3x3
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH     = FP_WIDTH,
  parameter int QINT      = FP_QINT,
  parameter int QFRAC     = FP_QFRAC,
  parameter int ACC_WIDTH = FP_ACC_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic                 sample_last,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 valid_out,
  output logic [9*WIDTH-1:0]   A_flat,
  output logic [3*WIDTH-1:0]   B_flat,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic                 sat_err,
  output logic                 underdetermined
);

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(FP_ONE);

  acc_state_t           state_q, state_d;
  logic [1:0]           drain_q, drain_d;
  logic [ACC_WIDTH-1:0] s_q [5];
  logic [ACC_WIDTH-1:0] s_d [5];
  logic [ACC_WIDTH-1:0] t_q [3];
  logic [ACC_WIDTH-1:0] t_d [3];
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 flag_q, flag_d;

  logic [WIDTH-1:0]     a_q [9];
  logic [WIDTH-1:0]     a_d [9];
  logic [WIDTH-1:0]     b_q [3];
  logic [WIDTH-1:0]     b_d [3];
  logic [CNT_WIDTH-1:0] cnt_out_q, cnt_out_d;
  logic                 sat_q, sat_d, under_q, under_d, valid_q, valid_d;

  logic                 accept;
  logic                 p_valid, p_sat;
  logic [WIDTH-1:0]     p_x, p_x2, p_x3, p_x4, p_y, p_xy, p_x2y;
  logic [WIDTH-1:0]     add_s [5];
  logic [WIDTH-1:0]     add_t [3];
  acc_sum_t             s_sum [5];
  acc_sum_t             t_sum [3];
  fx_sat_t              s_nar [5];
  fx_sat_t              t_nar [3];
  logic                 nar_ovf;

  assign sample_ready = (state_q == ST_ACCUM) && !rst;
  assign accept       = sample_valid && sample_ready;

  regression_basis_pipe #(.WIDTH(WIDTH), .QFRAC(QFRAC)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .x        (x),
    .y        (y),
    .out_valid(p_valid),
    .out_x    (p_x),
    .out_x2   (p_x2),
    .out_x3   (p_x3),
    .out_x4   (p_x4),
    .out_y    (p_y),
    .out_xy   (p_xy),
    .out_x2y  (p_x2y),
    .out_sat  (p_sat)
  );

  function automatic logic [ACC_WIDTH-1:0] ext_acc(input logic [WIDTH-1:0] v);
    return {{(ACC_WIDTH-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic [2*WIDTH-1:0] ext_wide(input logic [ACC_WIDTH-1:0] v);
    return {{(2*WIDTH-ACC_WIDTH){v[ACC_WIDTH-1]}}, v};
  endfunction

  always_comb begin
    add_s[0] = ONE_W;
    add_s[1] = p_x;
    add_s[2] = p_x2;
    add_s[3] = p_x3;
    add_s[4] = p_x4;
    add_t[0] = p_y;
    add_t[1] = p_xy;
    add_t[2] = p_x2y;
    nar_ovf  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_sum[i] = acc_add(s_q[i], ext_acc(add_s[i]));
      s_nar[i] = fx_sat(ext_wide(s_q[i]));
      nar_ovf  = nar_ovf | s_nar[i].ovf;
    end
    for (int i = 0; i < 3; i++) begin
      t_sum[i] = acc_add(t_q[i], ext_acc(add_t[i]));
      t_nar[i] = fx_sat(ext_wide(t_q[i]));
      nar_ovf  = nar_ovf | t_nar[i].ovf;
    end
  end

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    s_d       = s_q;
    t_d       = t_q;
    count_d   = count_q;
    flag_d    = flag_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_out_d = cnt_out_q;
    sat_d     = sat_q;
    under_d   = under_q;
    valid_d   = 1'b0;

    if (p_valid) begin
      for (int i = 0; i < 5; i++) begin
        s_d[i] = s_sum[i].val;
        flag_d = flag_d | s_sum[i].ovf;
      end
      for (int i = 0; i < 3; i++) begin
        t_d[i] = t_sum[i].val;
        flag_d = flag_d | t_sum[i].ovf;
      end
      flag_d = flag_d | p_sat;
      if (count_q != '1) count_d = count_q + 1'b1;
    end

    case (state_q)
      ST_ACCUM: begin
        if (accept && sample_last) begin
          state_d = ST_DRAIN;
          drain_d = 2'd3;
        end
      end
      // The last sample lands in the accumulators on the edge that enters EMIT.
      ST_DRAIN: begin
        drain_d = drain_q - 2'd1;
        if (drain_q == 2'd1) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        for (int i = 0; i < 9; i++) a_d[i] = s_nar[(i / 3) + (i % 3)].val;
        for (int i = 0; i < 3; i++) b_d[i] = t_nar[i].val;
        cnt_out_d = count_q;
        sat_d     = flag_q | nar_ovf;
        under_d   = (count_q < CNT_WIDTH'(3));
        valid_d   = 1'b1;
        s_d       = '{default: '0};
        t_d       = '{default: '0};
        count_d   = '0;
        flag_d    = 1'b0;
        drain_d   = 2'd0;
        state_d   = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      drain_q   <= 2'd0;
      s_q       <= '{default: '0};
      t_q       <= '{default: '0};
      count_q   <= '0;
      flag_q    <= 1'b0;
      a_q       <= '{default: '0};
      b_q       <= '{default: '0};
      cnt_out_q <= '0;
      sat_q     <= 1'b0;
      under_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      s_q       <= s_d;
      t_q       <= t_d;
      count_q   <= count_d;
      flag_q    <= flag_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_out_q <= cnt_out_d;
      sat_q     <= sat_d;
      under_q   <= under_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    A_flat = '0;
    B_flat = '0;
    for (int i = 0; i < 9; i++) A_flat[i*WIDTH +: WIDTH] = a_q[i];
    for (int i = 0; i < 3; i++) B_flat[i*WIDTH +: WIDTH] = b_q[i];
  end

  assign valid_out       = valid_q;
  assign sample_count    = cnt_out_q;
  assign sat_err         = sat_q;
  assign underdetermined = under_q;

endmodule

// File: tb/tb_regression_accumulator_3x3.sv
// Directed bench for regression_accumulator_3x3: hand-computed Q16.16 normal equations
// for small batches, flow control during drain, saturation and mid-drain reset.
module tb_regression_accumulator_3x3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sample_valid = 1'b0;
  logic         sample_ready;
  logic         sample_last = 1'b0;
  logic [31:0]  x = '0;
  logic [31:0]  y = '0;
  logic         valid_out;
  logic [287:0] A_flat;
  logic [95:0]  B_flat;
  logic [15:0]  sample_count;
  logic         sat_err;
  logic         underdetermined;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  regression_accumulator_3x3 dut (
    .clk            (clk),
    .rst            (rst),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .sample_last    (sample_last),
    .x              (x),
    .y              (y),
    .valid_out      (valid_out),
    .A_flat         (A_flat),
    .B_flat         (B_flat),
    .sample_count   (sample_count),
    .sat_err        (sat_err),
    .underdetermined(underdetermined)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one sample after 'gap' idle cycles; returns the cycle index of the accepting edge.
  task automatic send(input logic [31:0] xv, input logic [31:0] yv, input logic lv,
                      input int gap, output int k);
    bit acc;
    int guard;
    sample_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b1;
    x = xv;
    y = yv;
    sample_last = lv;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = sample_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    sample_valid = 1'b0;
    sample_last = 1'b0;
    k = cyc;
    if (!acc) chk("accept_timeout", 288'(acc), 288'(1));
  endtask

  // Watch ten cycles: count valid pulses, latency of the first, and not-ready cycles.
  task automatic observe(input int k, output int pulses, output int lat, output int rlow);
    pulses = 0;
    lat = -1;
    rlow = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        pulses++;
        if (pulses == 1) lat = cyc - k;
      end
      if (sample_ready !== 1'b1) rlow++;
    end
    @(posedge clk);
    #1;
  endtask

  logic [287:0] exp_a_main, exp_a_one, exp_a_unit;
  logic [95:0]  exp_b_main, exp_b_one, exp_b_unit;

  initial begin
    int k, pulses, lat, rlow;
    exp_a_main = {32'h620000, 32'h240000, 32'hE0000,
                  32'h240000, 32'hE0000,  32'h60000,
                  32'hE0000,  32'h60000,  32'h30000};
    exp_b_main = {32'h620000, 32'h240000, 32'hE0000};
    exp_a_one  = {32'h1000, 32'h2000, 32'h4000,
                  32'h2000, 32'h4000, 32'h8000,
                  32'h4000, 32'h8000, 32'h10000};
    exp_b_one  = {32'hFFFFC000, 32'hFFFF8000, 32'hFFFF0000};
    exp_a_unit = {9{32'h10000}};
    exp_b_unit = {3{32'h10000}};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 288'(sample_ready), 288'(0));
    chk("reset_valid", 288'(valid_out), 288'(0));
    chk("reset_A", A_flat, 288'(0));
    chk("reset_B", 288'(B_flat), 288'(0));
    chk("reset_count", 288'(sample_count), 288'(0));
    chk("reset_flags", 288'({sat_err, underdetermined}), 288'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 288'(sample_ready), 288'(1));
    @(posedge clk);
    #1;

    // Back-to-back batch (1,1),(2,4),(3,9)
    send(32'h10000, 32'h10000, 1'b0, 0, k);
    send(32'h20000, 32'h40000, 1'b0, 0, k);
    send(32'h30000, 32'h90000, 1'b1, 0, k);
    observe(k, pulses, lat, rlow);
    chk("main_pulses", 288'(pulses), 288'(1));
    chk("main_latency", 288'(lat), 288'(4));
    chk("main_ready_low", 288'(rlow), 288'(4));
    chk("main_A", A_flat, exp_a_main);
    chk("main_B", 288'(B_flat), 288'(exp_b_main));
    chk("main_count", 288'(sample_count), 288'(3));
    chk("main_flags", 288'({sat_err, underdetermined}), 288'(0));

    // Same batch with random gaps
    send(32'h10000, 32'h10000, 1'b0, $urandom_range(0, 3), k);
    send(32'h20000, 32'h40000, 1'b0, $urandom_range(1, 4), k);
    send(32'h30000, 32'h90000, 1'b1, $urandom_range(1, 4), k);
    observe(k, pulses, lat, rlow);
    chk("gap_pulses", 288'(pulses), 288'(1));
    chk("gap_latency", 288'(lat), 288'(4));
    chk("gap_ready_low", 288'(rlow), 288'(4));
    chk("gap_A", A_flat, exp_a_main);
    chk("gap_B", 288'(B_flat), 288'(exp_b_main));
    chk("gap_count", 288'(sample_count), 288'(3));
    chk("gap_flags", 288'({sat_err, underdetermined}), 288'(0));

    // Single sample x=0.5, y=-1.0
    send(32'h8000, 32'hFFFF0000, 1'b1, 0, k);
    observe(k, pulses, lat, rlow);
    chk("one_latency", 288'(lat), 288'(4));
    chk("one_A", A_flat, exp_a_one);
    chk("one_B", 288'(B_flat), 288'(exp_b_one));
    chk("one_count", 288'(sample_count), 288'(1));
    chk("one_under", 288'(underdetermined), 288'(1));
    chk("one_sat", 288'(sat_err), 288'(0));

    // Saturating sample x=200.0, then a clean batch
    send(32'hC80000, 32'h10000, 1'b1, 0, k);
    observe(k, pulses, lat, rlow);
    chk("sat_pulses", 288'(pulses), 288'(1));
    chk("sat_flag", 288'(sat_err), 288'(1));
    chk("sat_S2", 288'(A_flat[2*32 +: 32]), 288'(32'h7FFFFFFF));
    chk("sat_count", 288'(sample_count), 288'(1));
    send(32'h10000, 32'h10000, 1'b0, 1, k);
    send(32'h20000, 32'h40000, 1'b0, 0, k);
    send(32'h30000, 32'h90000, 1'b1, 0, k);
    observe(k, pulses, lat, rlow);
    chk("clean_sat", 288'(sat_err), 288'(0));
    chk("clean_A", A_flat, exp_a_main);

    // Valid offered during DRAIN/EMIT must be ignored
    send(32'h10000, 32'h10000, 1'b1, 0, k);
    sample_valid = 1'b1;
    x = 32'h50000;
    y = 32'h50000;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    observe(k, pulses, lat, rlow);
    chk("drain_pulses", 288'(pulses), 288'(1));
    chk("drain_latency", 288'(lat), 288'(4));
    chk("drain_A", A_flat, exp_a_unit);
    chk("drain_B", 288'(B_flat), 288'(exp_b_unit));
    chk("drain_count", 288'(sample_count), 288'(1));

    // Reset during DRAIN discards the batch
    send(32'h10000, 32'h10000, 1'b0, 0, k);
    send(32'h20000, 32'h40000, 1'b0, 0, k);
    send(32'h30000, 32'h90000, 1'b1, 0, k);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drain_ready", 288'(sample_ready), 288'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    observe(k, pulses, lat, rlow);
    chk("rst_drain_pulses", 288'(pulses), 288'(0));
    chk("rst_drain_A", A_flat, 288'(0));
    send(32'h10000, 32'h10000, 1'b0, 0, k);
    send(32'h20000, 32'h40000, 1'b0, 0, k);
    send(32'h30000, 32'h90000, 1'b1, 0, k);
    observe(k, pulses, lat, rlow);
    chk("post_rst_latency", 288'(lat), 288'(4));
    chk("post_rst_A", A_flat, exp_a_main);
    chk("post_rst_B", 288'(B_flat), 288'(exp_b_main));
    chk("post_rst_count", 288'(sample_count), 288'(3));
    chk("post_rst_flags", 288'({sat_err, underdetermined}), 288'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regression_accumulator_3x3.md
Name: regression_accumulator_3x3

Overview:
- Streaming producer of the normal equations for the 3×3 least-squares solver (basis phi = [1, x, x²]).
- Consumes one (x, y) path sample per handshake and accumulates A = Σ phi·phiᵀ and B = Σ phi·y in Q16.16.
- On the batch's last sample it drains its pipeline, then emits A_flat/B_flat with a one-cycle valid pulse, directly compatible with the solver's valid_in/A_flat/B_flat inputs.

Parameters:
- WIDTH, fpga_cfg_pkg::FP_WIDTH (32), data word width.
- QINT, fpga_cfg_pkg::FP_QINT (16), integer bits.
- QFRAC, fpga_cfg_pkg::FP_QFRAC (16), fraction bits.
- ACC_WIDTH, 48, internal signed accumulator width (≥ WIDTH+8).
- CNT_WIDTH, 16, sample counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sample_valid  in  1  sample offered
- sample_ready  out  1  block can accept a sample
- sample_last  in  1  qualifies final sample of batch
- x  in  WIDTH  signed Q16.16 regressor (e.g. spot price)
- y  in  WIDTH  signed Q16.16 response (discounted payoff)
- valid_out  out  1  one-cycle pulse: A_flat/B_flat/count/flags valid
- A_flat  out  WIDTH×[0:8]  row-major A, signed Q16.16
- B_flat  out  WIDTH×[0:2]  B, signed Q16.16
- sample_count  out  CNT_WIDTH  samples in emitted batch
- sat_err  out  1  any saturation occurred in the batch
- underdetermined  out  1  sample_count < 3

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0 (sample_ready=0 during reset, 1 the cycle after); state ACCUM; accumulators and count cleared; pipeline valids cleared.
- Handshake: a sample is accepted on a rising edge where sample_valid & sample_ready. sample_ready = (state==ACCUM).
- Datapath pipeline, 3 register stages after acceptance:
  - P1: register x, y, last.
  - P2: x2 = sat((x·x)>>>QFRAC); xy = sat((x·y)>>>QFRAC).
  - P3: x3 = sat((x2·x)>>>QFRAC); x4 = sat((x2·x2)>>>QFRAC); x2y = sat((x2·y)>>>QFRAC).
  - All products are full 2·WIDTH signed with arithmetic shift (floor). sat() clamps to the WIDTH signed range and raises the batch saturation flag.
- Accumulate stage (edge k+3 for a sample accepted at edge k), sign-extended to ACC_WIDTH:
  - S0+=1.0 (1<<QFRAC), S1+=x, S2+=x2, S3+=x3, S4+=x4.
  - T0+=y, T1+=xy, T2+=x2y.
  - count+=1, saturating at all-ones.
  - Accumulator overflow clamps to the ACC_WIDTH range and sets the flag.
- Output mapping, each narrowed to WIDTH with saturation, which also sets the flag:
  - A_flat = [S0,S1,S2, S1,S2,S3, S2,S3,S4].
  - B_flat = [T0,T1,T2].
- FSM:
  - ACCUM: accepting samples. Acceptance with sample_last → DRAIN, with the drain counter loaded to 3.
  - DRAIN: sample_ready=0. Decrement each cycle; at 0 → EMIT. All in-flight samples have been accumulated by then.
  - EMIT: one cycle. Output registers load and valid_out=1 on the following cycle, i.e. valid_out is high the cycle after edge k+4 for the last sample accepted at edge k. Accumulators, count and flag clear on the same edge. → ACCUM.
- Outputs hold their values between pulses. valid_out is never high on two consecutive cycles.
- No backpressure on the output: the solver always accepts.
- sample_last with count reaching 1 or 2 still emits, with underdetermined=1 (the solver flags the singular pivot).
- Reset mid-batch or mid-drain discards all partial sums; no valid_out is produced for that batch.
- sample_valid high while sample_ready=0 is ignored; the data is not captured.

Decomposition:
- fpga_cfg_pkg adds:
  - localparam FP_ONE = 1<<FP_QFRAC.
  - localparam FP_ACC_WIDTH = 48.
  - function fx_sat(narrowing, returning value and overflow bit).
- One sub-module: regression_basis_pipe, covering P1–P3 (x,y → 1,x,x2,x3,x4,y,xy,x2y plus valid/last/sat). The accumulators and FSM stay in the top.

Test Plan:
- Samples (1.0,1.0),(2.0,4.0),(3.0,9.0) with last on the third, back-to-back → one pulse 4 cycles after last accept:
  - A_flat = 0x30000,0x60000,0xE0000, 0x60000,0xE0000,0x240000, 0xE0000,0x240000,0x620000.
  - B_flat = 0xE0000,0x240000,0x620000.
  - count=3, flags 0.
- Same batch with sample_valid gapped randomly → identical outputs. sample_ready is low exactly 4 cycles (DRAIN+EMIT) after the last accept.
- Single sample x=0.5 (0x8000), y=-1.0, last → A_flat[0]=0x10000, A_flat[1]=0x8000, A_flat[8]=0x1000, B_flat=[0xFFFF0000,0xFFFF8000,0xFFFFC000], underdetermined=1.
- x=200.0 (0xC80000) → x2 saturates to 0x7FFFFFFF. The batch emits with sat_err=1, and the next clean batch has sat_err=0.
- sample_valid asserted during DRAIN with x=5.0 → not accepted; the emitted sums exclude it.
- rst pulsed one cycle during DRAIN → no valid_out. A subsequent 3-sample batch matches the first scenario exactly.
